// File: rtl/mp3_frame_packer_if.sv
// Source/sink bundle for the MP3 frame packer: section byte sources, frame control and the serial byte output.
interface mp3_frame_packer_if;
    logic        start;
    logic [1:0]  mode;
    logic        prot;
    logic [10:0] frame_size;
    logic [7:0]  hdr_din, crc_din, si_din, md_din;
    logic        hdr_iv, crc_iv, si_iv, md_iv;
    logic        hdr_rdy, crc_rdy, si_rdy, md_rdy;
    logic        out_rdy;
    logic [7:0]  d_out;
    logic        d_ov;
    logic        busy;
    logic        done;
    logic        size_err;
    logic [15:0] frame_count;

    modport slave (
        input  start, mode, prot, frame_size,
        input  hdr_din, crc_din, si_din, md_din,
        input  hdr_iv, crc_iv, si_iv, md_iv,
        input  out_rdy,
        output hdr_rdy, crc_rdy, si_rdy, md_rdy,
        output d_out, d_ov, busy, done, size_err, frame_count
    );

    modport master (
        output start, mode, prot, frame_size,
        output hdr_din, crc_din, si_din, md_din,
        output hdr_iv, crc_iv, si_iv, md_iv,
        output out_rdy,
        input  hdr_rdy, crc_rdy, si_rdy, md_rdy,
        input  d_out, d_ov, busy, done, size_err, frame_count
    );
endinterface

// File: rtl/mp3_frame_packer.sv
// Serializes header, optional CRC, side info and main data into one MP3 frame byte stream.
// Latency: 1 cycle from source transfer to d_ov; sustains 1 byte/cycle when out_rdy stays high.
// Backpressure: d_out holds while out_rdy is low; the active section rdy drops until the byte drains.
// Optional frame counter enabled by PACKER_FRAME_COUNT_EN.
module mp3_frame_packer (
    input  logic                 clk,
    input  logic                 rst_n,
    mp3_frame_packer_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, HDR, CRC, SIDE, MAIN, DRAIN} state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] side_len;
    logic [10:0] main_len;
    logic        has_crc;
    logic [7:0]  d_out_q;
    logic        d_ov_q;
    logic        done_q;
    logic        size_err_q;

    logic        can_load;
    logic        in_section;
    logic        cur_iv;
    logic [7:0]  cur_din;
    logic        sec_last;
    logic        xfer;
    logic [10:0] crc_n;
    logic [10:0] side_n;
    logic [10:0] ovh_n;

    // The output register can take a new byte when empty or being drained this cycle.
    assign can_load   = !d_ov_q || bus.out_rdy;
    assign in_section = (state == HDR) || (state == CRC) || (state == SIDE) || (state == MAIN);
    assign xfer       = in_section && can_load && cur_iv;

    always_comb begin
        cur_iv   = 1'b0;
        cur_din  = 8'h00;
        sec_last = 1'b0;
        case (state)
            HDR:  begin cur_iv = bus.hdr_iv; cur_din = bus.hdr_din; sec_last = (cnt == 11'd3); end
            CRC:  begin cur_iv = bus.crc_iv; cur_din = bus.crc_din; sec_last = (cnt == 11'd1); end
            SIDE: begin cur_iv = bus.si_iv;  cur_din = bus.si_din;  sec_last = (cnt == side_len - 11'd1); end
            MAIN: begin cur_iv = bus.md_iv;  cur_din = bus.md_din;  sec_last = (cnt == main_len - 11'd1); end
            default: ;
        endcase
    end

    always_comb begin
        crc_n  = bus.prot ? 11'd0 : 11'd2;
        side_n = (bus.mode == 2'd3) ? 11'd17 : 11'd32;
        ovh_n  = 11'd4 + crc_n + side_n;
    end

    assign bus.hdr_rdy  = (state == HDR)  && can_load;
    assign bus.crc_rdy  = (state == CRC)  && can_load;
    assign bus.si_rdy   = (state == SIDE) && can_load;
    assign bus.md_rdy   = (state == MAIN) && can_load;
    assign bus.d_out    = d_out_q;
    assign bus.d_ov     = d_ov_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.size_err = size_err_q;

`ifdef PACKER_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;
    assign bus.frame_count = frame_cnt_q;
`else
    assign bus.frame_count = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 11'd0;
            side_len   <= 11'd0;
            main_len   <= 11'd0;
            has_crc    <= 1'b0;
            d_out_q    <= 8'h00;
            d_ov_q     <= 1'b0;
            done_q     <= 1'b0;
            size_err_q <= 1'b0;
`ifdef PACKER_FRAME_COUNT_EN
            frame_cnt_q <= 16'h0000;
`endif
        end else begin
            done_q     <= 1'b0;
            size_err_q <= 1'b0;

            if (xfer) begin
                d_out_q <= cur_din;
                d_ov_q  <= 1'b1;
                cnt     <= sec_last ? 11'd0 : cnt + 11'd1;
            end else if (bus.out_rdy) begin
                d_ov_q  <= 1'b0;
            end

            case (state)
                IDLE: if (bus.start) begin
                    has_crc  <= !bus.prot;
                    side_len <= side_n;
                    cnt      <= 11'd0;
                    state    <= HDR;
                    // Undersized frames still carry header/CRC/side; main data is dropped.
                    if (bus.frame_size < ovh_n) begin
                        main_len   <= 11'd0;
                        size_err_q <= 1'b1;
                    end else begin
                        main_len   <= bus.frame_size - ovh_n;
                    end
                end
                HDR:  if (xfer && sec_last) state <= has_crc ? CRC : SIDE;
                CRC:  if (xfer && sec_last) state <= SIDE;
                SIDE: if (xfer && sec_last) state <= (main_len == 11'd0) ? DRAIN : MAIN;
                MAIN: if (xfer && sec_last) state <= DRAIN;
                DRAIN: if (can_load) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
`ifdef PACKER_FRAME_COUNT_EN
                    frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp3_frame_packer.sv
// Scoreboard bench for mp3_frame_packer: expected byte streams queued at start, popped by an output monitor.
module tb_mp3_frame_packer;
    logic clk;
    logic rst_n;
    mp3_frame_packer_if bus();

    mp3_frame_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // source state
    int unsigned h_idx = 0, c_idx = 0, s_idx = 0, m_idx = 0;
    int crc_x = 0, si_x = 0, md_x = 0;
    bit tgl = 1'b0, md_rand = 1'b0;
    bit fl_h = 1'b0, fl_c = 1'b0, fl_s = 1'b0, fl_m = 1'b0;

    // monitor state
    int cyc = 0, mon_bytes = 0, done_cnt = 0, serr_cnt = 0;
    int last_acc = 0, done_cyc = 0;
    bit prev_hold = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    int frames = 0;

    function automatic logic [7:0] hdr_pat(int unsigned i); return 8'(i) ^ 8'hA5; endfunction
    function automatic logic [7:0] crc_pat(int unsigned i); return 8'(i) ^ 8'h3C; endfunction
    function automatic logic [7:0] si_pat(int unsigned i);  return 8'(i) ^ 8'hC3; endfunction
    function automatic logic [7:0] md_pat(int unsigned i);  return 8'(i * 7) ^ 8'h5A; endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Source driver: accounts for last edge's transfers, then presents the next bytes.
    initial begin
        forever begin
            @(negedge clk);
            if (fl_h) h_idx++;
            if (fl_c) begin c_idx++; crc_x++; end
            if (fl_s) begin s_idx++; si_x++;  end
            if (fl_m) begin m_idx++; md_x++;  end
            bus.out_rdy = tgl ? !bus.out_rdy : 1'b1;
            bus.md_iv   = md_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.hdr_din = hdr_pat(h_idx);
            bus.crc_din = crc_pat(c_idx);
            bus.si_din  = si_pat(s_idx);
            bus.md_din  = md_pat(m_idx);
            #1;
            fl_h = rst_n && bus.hdr_rdy && bus.hdr_iv;
            fl_c = rst_n && bus.crc_rdy && bus.crc_iv;
            fl_s = rst_n && bus.si_rdy  && bus.si_iv;
            fl_m = rst_n && bus.md_rdy  && bus.md_iv;
        end
    end

    // Output monitor: compares each accepted byte against the scoreboard queue.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_ov",  int'(bus.d_ov), 1);
                    chk("hold_dat", int'(bus.d_out), int'(prev_dat));
                end
                if (bus.d_ov && bus.out_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL extra_byte: got %0d with empty scoreboard", bus.d_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", int'(bus.d_out), int'(e));
                    end
                    mon_bytes++;
                    last_acc = cyc;
                end
                if (bus.done) begin done_cnt++; done_cyc = cyc; end
                if (bus.size_err) serr_cnt++;
                prev_hold = bus.d_ov && !bus.out_rdy;
                prev_dat  = bus.d_out;
            end
        end
    end

    task automatic push_exp(input int n_crc, input int n_si, input int n_md);
        for (int i = 0; i < 4; i++)    exp_q.push_back(hdr_pat(h_idx + i));
        for (int i = 0; i < n_crc; i++) exp_q.push_back(crc_pat(c_idx + i));
        for (int i = 0; i < n_si; i++)  exp_q.push_back(si_pat(s_idx + i));
        for (int i = 0; i < n_md; i++)  exp_q.push_back(md_pat(m_idx + i));
    endtask

    // Start a frame, then scramble the controls and fire a stray start that must be ignored.
    task automatic pulse_start(input logic [1:0] m, input logic p, input logic [10:0] fs);
        @(negedge clk);
        bus.mode = m; bus.prot = p; bus.frame_size = fs; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.mode = ~m; bus.prot = ~p; bus.frame_size = 11'd5;
        #3;
        chk("busy_run", int'(bus.busy), 1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [1:0] m, input logic p, input logic [10:0] fs,
                             input int n_bytes, input int n_crc, input int n_si, input int n_md, input int n_serr);
        int b0, c0, s0, m0, d0, e0;
        b0 = mon_bytes; c0 = crc_x; s0 = si_x; m0 = md_x; d0 = done_cnt; e0 = serr_cnt;
        push_exp(n_crc, n_si, n_md);
        pulse_start(m, p, fs);
        for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
            @(negedge clk);
            #3;
        end
        if (done_cnt == d0) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: no done after 5000 cycles", nm);
        end
        frames++;
        chk({nm, "_bytes"}, mon_bytes - b0, n_bytes);
        chk({nm, "_crc"},   crc_x - c0, n_crc);
        chk({nm, "_side"},  si_x - s0, n_si);
        chk({nm, "_main"},  md_x - m0, n_md);
        chk({nm, "_serr"},  serr_cnt - e0, n_serr);
        chk({nm, "_done"},  done_cnt - d0, 1);
        chk({nm, "_dlat"},  done_cyc - last_acc, 1);
        chk({nm, "_qleft"}, exp_q.size(), 0);
        chk({nm, "_busy"},  int'(bus.busy), 0);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_dov"},  int'(bus.d_ov), 0);
        chk({nm, "_dout"}, int'(bus.d_out), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_serr"}, int'(bus.size_err), 0);
        chk({nm, "_rdy"},  int'({bus.hdr_rdy, bus.crc_rdy, bus.si_rdy, bus.md_rdy}), 0);
        chk({nm, "_fc"},   int'(bus.frame_count), 0);
    endtask

    function automatic int exp_fc(input int n);
`ifdef PACKER_FRAME_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    initial begin
        int b0, d0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 2'd0; bus.prot = 1'b1; bus.frame_size = 11'd0;
        bus.hdr_iv = 1'b1; bus.crc_iv = 1'b1; bus.si_iv = 1'b1; bus.md_iv = 1'b1;
        bus.hdr_din = 8'h00; bus.crc_din = 8'h00; bus.si_din = 8'h00; bus.md_din = 8'h00;
        bus.out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("m0_p1_417", 2'd0, 1'b1, 11'd417, 417, 0, 32, 381, 0);
        run_frame("m3_p0_104", 2'd3, 1'b0, 11'd104, 104, 2, 17, 81, 0);
        run_frame("m0_p0_20",  2'd0, 1'b0, 11'd20,  38,  2, 32, 0,   1);
        chk("fc_three", int'(bus.frame_count), exp_fc(3));

        tgl = 1'b1; md_rand = 1'b1;
        run_frame("bp_m3_100", 2'd3, 1'b1, 11'd100, 100, 0, 17, 79, 0);
        tgl = 1'b0; md_rand = 1'b0;
        chk("fc_four", int'(bus.frame_count), exp_fc(frames));

        // abandon a frame mid-stream
        b0 = mon_bytes; d0 = done_cnt;
        push_exp(0, 32, 381);
        pulse_start(2'd0, 1'b1, 11'd417);
        for (int k = 0; k < 200 && (mon_bytes - b0) < 10; k++) begin
            @(negedge clk);
            #3;
        end
        chk("rst_reach10", int'((mon_bytes - b0) >= 10), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("midrst_nodone", done_cnt - d0, 0);
        frames = 0;

        run_frame("after_rst", 2'd0, 1'b1, 11'd60, 60, 0, 32, 24, 0);
        chk("fc_after_rst", int'(bus.frame_count), exp_fc(1));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
